stepper_axis_ctrl: RTL and testbench
====================================

# stepper_axis_ctrl

Six-axis stepper-motor positioning controller. After reset it homes all six axes against their origin switches, then accepts absolute BCD target positions for one axis at a time. It converts each target into a direction and a step count, and emits step pulses on that axis's driver outputs. It sits between the host command interface and six external stepper drivers (PU/DR/MF inputs).

## Interface
Parameters:
- PULSE_HALF, 50: clock cycles per half step period (PU high time = low time).
- NAXIS, 6: number of axes (fixed at 6 for this release).

Ports:
- sysclk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- Motor  in  6  one-hot axis select of the command; 0 = no command.
- TValue0  in  4  BCD hundreds digit of the target position.
- TValue1  in  4  BCD tens digit.
- TValue2  in  4  BCD units digit.
- Stop  in  6  origin switch per axis, active high.
- PU  out  6  step pulse per axis.
- DR  out  6  direction per axis; 1 = forward (position increasing), 0 = reverse/toward origin.
- MF  out  6  motor-free per axis; 1 = driver released.
- Busy  out  1  a move is in progress.
- INIT  out  1  all six axes homed.
- initFlag  out  6  per-axis homed flag.

## Operation
- **Reset (rst=0):**
  - PU=0, DR=0, MF=6'h3F, Busy=0, INIT=0, initFlag=0.
  - Positions cleared, command buffer empty.
- **HOMING:** entered on the first cycle after rst=1.
  - MF=0 and DR=0 on all axes.
  - All six axes pulse concurrently.
  - When Stop[i]=1 is sampled: PU[i] is forced 0 next cycle, initFlag[i]=1, pos[i]=0, and axis i stops pulsing permanently.
  - INIT=1 once initFlag=6'h3F; state becomes IDLE.
  - Stop is ignored outside HOMING.
- **Command capture:**
  - Legal only when INIT=1.
  - A command is the tuple {Motor,TValue0..2}. It is captured when the tuple differs from its value in the previous cycle, Motor is one-hot, and every digit ≤9.
  - Other tuples are dropped: Motor=0, multi-hot, or any digit >9.
  - Captured commands go into a one-deep buffer; a newer capture overwrites an unexecuted one.
- **Dispatch (Control side):**
  - Occurs when the buffer is full and Busy=0.
  - target = 100·TValue0 + 10·TValue1 + TValue2 (10-bit, 0..999).
  - If target>pos[i]: DROut=1, PulseNum=target−pos[i]. If target<pos[i]: DROut=0, PulseNum=pos[i]−target.
  - If target=pos[i]: the buffer is cleared and nothing is issued.
  - pos[i] is updated to target at dispatch.
- **Pulse side (sub-module):**
  - On start: latch axis, DR and PulseNum.
  - Drive DR[i] one cycle before the first PU rising edge.
  - Emit exactly PulseNum pulses of period 2·PULSE_HALF, then release Busy.
  - PU of unselected axes stays 0. DR[i] holds its last value after the move.

## Timing
- Capture: 1 cycle after the input change.
- Dispatch: the cycle after capture when idle; otherwise the cycle after Busy falls.
- Control→pulse handshake:
  - Control holds MotorOut nonzero for exactly one cycle (start strobe) with PulseNum/DROut valid in that cycle.
  - Busy rises the following cycle and stays high until the low half of the last pulse ends.
- Move duration: 1 + 2·PULSE_HALF·N cycles for N steps.
- A new command arriving while Busy=1 is buffered, never aborts the move.
- Reset mid-move or mid-homing: the reset state takes effect the next edge, and homing restarts after release.
- PulseNum is 10-bit; the maximum step count is 999.

## Structure
- Top stepper_axis_ctrl contains the command/position logic (capture, buffer, BCD-to-binary conversion, position registers, dispatch FSM IDLE/DISPATCH/WAIT).
- One sub-module, step_pulse_gen, holds the HOMING/RUN pulse FSM, half-period counter, step counter, and INIT/initFlag.
- Shared package stepper_pkg:
  - NAXIS and PULSE_HALF default.
  - Position type logic [9:0].
  - FSM state enums.
  - Direction constants DIR_FWD=1, DIR_REV=0.

## Test plan
- **Reset then homing:** pulse rst low for 100 cycles. Then assert Stop=6'b000001, 6'b000010 … 6'b100000 one at a time, 200 cycles each. Required: MF goes 6'h3F→0; each axis pulses with DR=0 until its Stop bit; initFlag fills bit by bit; INIT=1 after bit 5.
- **Forward move:** Motor=6'b000010, digits 0,1,0. Required: DR[1]=1, exactly 10 PU[1] pulses; Busy high for 1+1000 cycles (PULSE_HALF=50).
- **Reverse move:** then Motor=6'b000010, digits 0,0,3. Required: DR[1]=0, 7 pulses, pos[1]=3.
- **Axis 0 moves:** digits 0,0,5 then 0,0,9. Required: 5 forward pulses, then 4 forward pulses.
- **Buffer overwrite:** while axis 0 is Busy, apply 0,0,7 then 100 cycles later 0,0,5. Required: 0,0,7 is never executed; after the 9-target move, 4 reverse pulses.
- **Rejects:** Motor=6'b000011, or digit 4'hA, or a command before INIT. Required: no pulses, Busy stays 0.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and constants for the six-axis stepper controller.
package stepper_pkg;

  localparam int NAXIS_DEF      = 6;
  localparam int PULSE_HALF_DEF = 50;

  typedef logic [9:0] pos_t;

  typedef enum logic [1:0] {C_IDLE, C_DISPATCH, C_WAIT} ctrl_state_t;
  typedef enum logic [1:0] {P_HOMING, P_IDLE, P_RUN} pulse_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  function automatic pos_t bcd_to_bin(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    return pos_t'(h) * pos_t'(100) + pos_t'(t) * pos_t'(10) + pos_t'(u);
  endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Pulse engine: homes all axes concurrently after reset, then runs one
// axis at a time for a requested number of steps.
module step_pulse_gen
  import stepper_pkg::*;
#(
  parameter int PULSE_HALF = PULSE_HALF_DEF,
  parameter int NAXIS      = NAXIS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NAXIS-1:0] motor_out,
  input  pos_t             pulse_num,
  input  logic             dr_out,
  input  logic [NAXIS-1:0] stop,
  output logic [NAXIS-1:0] pu,
  output logic [NAXIS-1:0] dr,
  output logic [NAXIS-1:0] mf,
  output logic             busy,
  output logic             init,
  output logic [NAXIS-1:0] init_flag
);

  localparam logic [15:0] HALF_LAST = 16'(PULSE_HALF - 1);

  pulse_state_t     state, state_next;
  logic [15:0]      half_cnt;
  logic             phase;
  logic             setup;
  pos_t             steps_left;
  logic [NAXIS-1:0] axis;
  logic [NAXIS-1:0] dr_reg;
  logic [NAXIS-1:0] flags;
  logic             mf_reg;
  logic             half_done;
  logic             all_homed;

  assign half_done = (half_cnt == HALF_LAST);
  assign all_homed = &flags;

  // A move ends when the low half of the final pulse completes.
  always_comb begin
    state_next = state;
    case (state)
      P_HOMING: if (all_homed) state_next = P_IDLE;
      P_IDLE:   if (motor_out != '0) state_next = P_RUN;
      P_RUN:    if (!setup && half_done && !phase && steps_left == 10'd1) state_next = P_IDLE;
      default:  state_next = P_HOMING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= P_HOMING;
      half_cnt   <= '0;
      phase      <= 1'b0;
      setup      <= 1'b0;
      steps_left <= '0;
      axis       <= '0;
      dr_reg     <= '0;
      flags      <= '0;
      mf_reg     <= 1'b1;
    end else begin
      state  <= state_next;
      mf_reg <= 1'b0;
      case (state)
        P_HOMING: begin
          flags    <= flags | stop;
          half_cnt <= half_done ? '0 : half_cnt + 16'd1;
          if (half_done) phase <= ~phase;
        end
        // The setup cycle lets DR settle before the first rising edge.
        P_IDLE: if (motor_out != '0) begin
          axis       <= motor_out;
          dr_reg     <= (dr_reg & ~motor_out) | (motor_out & {NAXIS{dr_out}});
          steps_left <= pulse_num;
          setup      <= 1'b1;
          phase      <= 1'b0;
          half_cnt   <= '0;
        end
        P_RUN: begin
          if (setup) begin
            setup    <= 1'b0;
            phase    <= 1'b1;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_done ? '0 : half_cnt + 16'd1;
            if (half_done) begin
              phase <= ~phase;
              if (!phase) steps_left <= steps_left - 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pu = '0;
    if (state == P_HOMING)   pu = {NAXIS{phase}} & ~flags;
    else if (state == P_RUN) pu = {NAXIS{phase}} & axis;
  end

  assign dr        = dr_reg;
  assign mf        = {NAXIS{mf_reg}};
  assign busy      = (state == P_RUN);
  assign init      = all_homed;
  assign init_flag = flags;

endmodule

// File: rtl/stepper_axis_ctrl.sv
// Command side: captures BCD targets, keeps per-axis positions and hands
// direction/step-count jobs to the pulse engine.
module stepper_axis_ctrl
  import stepper_pkg::*;
#(
  parameter int PULSE_HALF = PULSE_HALF_DEF,
  parameter int NAXIS      = NAXIS_DEF
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [NAXIS-1:0] Motor,
  input  logic [3:0]       TValue0,
  input  logic [3:0]       TValue1,
  input  logic [3:0]       TValue2,
  input  logic [NAXIS-1:0] Stop,
  output logic [NAXIS-1:0] PU,
  output logic [NAXIS-1:0] DR,
  output logic [NAXIS-1:0] MF,
  output logic             Busy,
  output logic             INIT,
  output logic [NAXIS-1:0] initFlag
);

  ctrl_state_t      state, state_next;
  logic [NAXIS-1:0] prev_motor;
  logic [3:0]       prev_d0, prev_d1, prev_d2;
  logic             changed, motor_ok, digits_ok, capture;
  logic             buf_full;
  logic [NAXIS-1:0] buf_motor;
  pos_t             buf_target;
  logic [2:0]       buf_idx;
  pos_t             cur_pos;
  pos_t             pos [NAXIS];
  logic [NAXIS-1:0] axis_sel;
  logic [NAXIS-1:0] motor_out;
  pos_t             pulse_num;
  logic             dr_out;
  logic             dispatch_go, drop;

  assign changed   = {Motor, TValue0, TValue1, TValue2} != {prev_motor, prev_d0, prev_d1, prev_d2};
  assign motor_ok  = (Motor != '0) && ((Motor & (Motor - NAXIS'(1))) == '0);
  assign digits_ok = (TValue0 <= 4'd9) && (TValue1 <= 4'd9) && (TValue2 <= 4'd9);
  assign capture   = INIT && changed && motor_ok && digits_ok;

  always_comb begin
    buf_idx = '0;
    for (int i = 0; i < NAXIS; i++)
      if (buf_motor[i]) buf_idx = 3'(i);
  end

  assign cur_pos = pos[buf_idx];

  // A target equal to the current position is consumed without a move.
  always_comb begin
    state_next  = state;
    dispatch_go = 1'b0;
    drop        = 1'b0;
    motor_out   = '0;
    case (state)
      C_IDLE: if (buf_full && !Busy) begin
        if (buf_target != cur_pos) begin
          dispatch_go = 1'b1;
          state_next  = C_DISPATCH;
        end else begin
          drop = 1'b1;
        end
      end
      C_DISPATCH: begin
        motor_out  = axis_sel;
        state_next = C_WAIT;
      end
      C_WAIT:  if (!Busy) state_next = C_IDLE;
      default: state_next = C_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst) state <= C_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge sysclk) begin
    if (!rst) begin
      prev_motor <= '0;
      prev_d0    <= '0;
      prev_d1    <= '0;
      prev_d2    <= '0;
      buf_full   <= 1'b0;
      buf_motor  <= '0;
      buf_target <= '0;
      axis_sel   <= '0;
      pulse_num  <= '0;
      dr_out     <= DIR_REV;
      for (int i = 0; i < NAXIS; i++) pos[i] <= '0;
    end else begin
      prev_motor <= Motor;
      prev_d0    <= TValue0;
      prev_d1    <= TValue1;
      prev_d2    <= TValue2;
      if (capture) begin
        buf_full   <= 1'b1;
        buf_motor  <= Motor;
        buf_target <= bcd_to_bin(TValue0, TValue1, TValue2);
      end else if (dispatch_go || drop) begin
        buf_full <= 1'b0;
      end
      if (dispatch_go) begin
        axis_sel <= buf_motor;
        if (buf_target > cur_pos) begin
          dr_out    <= DIR_FWD;
          pulse_num <= buf_target - cur_pos;
        end else begin
          dr_out    <= DIR_REV;
          pulse_num <= cur_pos - buf_target;
        end
        pos[buf_idx] <= buf_target;
      end
    end
  end

  step_pulse_gen #(
    .PULSE_HALF(PULSE_HALF),
    .NAXIS     (NAXIS)
  ) u_pulse (
    .clk      (sysclk),
    .rst      (rst),
    .motor_out(motor_out),
    .pulse_num(pulse_num),
    .dr_out   (dr_out),
    .stop     (Stop),
    .pu       (PU),
    .dr       (DR),
    .mf       (MF),
    .busy     (Busy),
    .init     (INIT),
    .init_flag(initFlag)
  );

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Bench for stepper_axis_ctrl: homing, directed and random moves checked
// against a position model that counts observed step pulses.
module tb_stepper_axis_ctrl;

  localparam int PH = 4;

  logic       sysclk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Motor = '0;
  logic [3:0] TValue0 = '0, TValue1 = '0, TValue2 = '0;
  logic [5:0] Stop = '0;
  logic [5:0] PU, DR, MF, initFlag;
  logic       Busy, INIT;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [6] = '{default: 0};
  int busy_total = 0;
  logic [5:0] pu_prev = '0;
  int pos_model [6] = '{default: 0};

  stepper_axis_ctrl #(.PULSE_HALF(PH), .NAXIS(6)) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .Motor   (Motor),
    .TValue0 (TValue0),
    .TValue1 (TValue1),
    .TValue2 (TValue2),
    .Stop    (Stop),
    .PU      (PU),
    .DR      (DR),
    .MF      (MF),
    .Busy    (Busy),
    .INIT    (INIT),
    .initFlag(initFlag)
  );

  always #5 sysclk = ~sysclk;

  // Pulse and busy-cycle counters, sampled away from the active edge.
  always @(negedge sysclk) begin
    for (int i = 0; i < 6; i++)
      if (PU[i] === 1'b1 && pu_prev[i] !== 1'b1) pulse_cnt[i]++;
    pu_prev = PU;
    if (Busy === 1'b1) busy_total++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] m, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    @(posedge sysclk);
    #1;
    Motor   = m;
    TValue0 = h;
    TValue1 = t;
    TValue2 = u;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic waitBusy(input string tag, input logic level, input int max_cycles);
    int n = 0;
    while (Busy !== level && n < max_cycles) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput({tag, "_busy_wait"}, 32'(Busy), 32'(level));
  endtask

  task automatic runMove(input string tag, input int axis, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    int target, steps, other, b0;
    int p0 [6];
    logic exp_dir;
    target  = 100 * int'(h) + 10 * int'(t) + int'(u);
    steps   = (target > pos_model[axis]) ? target - pos_model[axis] : pos_model[axis] - target;
    exp_dir = (target > pos_model[axis]);
    p0      = pulse_cnt;
    b0      = busy_total;
    applyStimulus(6'(1 << axis), h, t, u);
    if (steps > 0) begin
      waitBusy(tag, 1'b1, 10);
      waitBusy(tag, 1'b0, 2 * PH * steps + 10);
    end
    tick(12);
    other = 0;
    for (int i = 0; i < 6; i++)
      if (i != axis) other += pulse_cnt[i] - p0[i];
    checkOutput({tag, "_pulses"}, 32'(pulse_cnt[axis] - p0[axis]), 32'(steps));
    checkOutput({tag, "_busy_len"}, 32'(busy_total - b0), 32'((steps > 0) ? 1 + 2 * PH * steps : 0));
    checkOutput({tag, "_other_axes"}, 32'(other), 32'd0);
    if (steps > 0) checkOutput({tag, "_dir"}, 32'(DR[axis]), 32'(exp_dir));
    pos_model[axis] = target;
    applyStimulus(6'd0, h, t, u);
  endtask

  task automatic rejectCmd(input string tag, input logic [5:0] m, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    int total0, total1, b0;
    total0 = 0;
    for (int i = 0; i < 6; i++) total0 += pulse_cnt[i];
    b0 = busy_total;
    applyStimulus(m, h, t, u);
    tick(16);
    total1 = 0;
    for (int i = 0; i < 6; i++) total1 += pulse_cnt[i];
    checkOutput({tag, "_pulses"}, 32'(total1 - total0), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_total - b0), 32'd0);
    applyStimulus(6'd0, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    int p0 [6];
    int bad, b0;
    logic [3:0] rh, rt, ru;
    int ra;

    $display("[TB] reset and homing");
    tick(100);
    checkOutput("reset_pu", 32'(PU), 32'd0);
    checkOutput("reset_dr", 32'(DR), 32'd0);
    checkOutput("reset_mf", 32'(MF), 32'h3F);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_init", 32'(INIT), 32'd0);
    checkOutput("reset_flags", 32'(initFlag), 32'd0);

    @(posedge sysclk);
    #1 rst = 1'b1;
    applyStimulus(6'b000010, 4'd0, 4'd1, 4'd0);
    tick(3);
    checkOutput("homing_mf", 32'(MF), 32'd0);

    for (int i = 0; i < 6; i++) begin
      p0 = pulse_cnt;
      @(posedge sysclk);
      #1 Stop = 6'(1 << i);
      tick(200);
      bad = 0;
      for (int j = 0; j < 6; j++) begin
        if (j < i && pulse_cnt[j] != p0[j]) bad++;
        if (j > i && pulse_cnt[j] == p0[j]) bad++;
      end
      checkOutput($sformatf("homing_flags_%0d", i), 32'(initFlag), 32'((1 << (i + 1)) - 1));
      checkOutput($sformatf("homing_pulsing_%0d", i), 32'(bad), 32'd0);
      checkOutput($sformatf("homing_dr_%0d", i), 32'(DR), 32'd0);
    end
    @(posedge sysclk);
    #1 Stop = '0;
    tick(2);
    checkOutput("init_done", 32'(INIT), 32'd1);
    tick(20);
    checkOutput("pre_init_cmd_busy", 32'(busy_total), 32'd0);
    applyStimulus(6'd0, 4'd0, 4'd0, 4'd0);

    $display("[TB] directed moves");
    runMove("fwd_ax1", 1, 4'd0, 4'd1, 4'd0);
    runMove("rev_ax1", 1, 4'd0, 4'd0, 4'd3);
    runMove("ax0_to5", 0, 4'd0, 4'd0, 4'd5);
    runMove("ax0_to9", 0, 4'd0, 4'd0, 4'd9);
    runMove("same_pos", 0, 4'd0, 4'd0, 4'd9);

    $display("[TB] buffer overwrite");
    p0 = pulse_cnt;
    b0 = busy_total;
    applyStimulus(6'b000001, 4'd0, 4'd2, 4'd0);
    waitBusy("ow_first", 1'b1, 10);
    tick(10);
    applyStimulus(6'b000001, 4'd0, 4'd0, 4'd7);
    tick(10);
    applyStimulus(6'b000001, 4'd0, 4'd0, 4'd5);
    waitBusy("ow_first", 1'b0, 2 * PH * 11 + 10);
    waitBusy("ow_second", 1'b1, 10);
    checkOutput("ow_dir", 32'(DR[0]), 32'd0);
    waitBusy("ow_second", 1'b0, 2 * PH * 15 + 10);
    tick(12);
    checkOutput("ow_pulses", 32'(pulse_cnt[0] - p0[0]), 32'd26);
    checkOutput("ow_busy_len", 32'(busy_total - b0), 32'((1 + 2 * PH * 11) + (1 + 2 * PH * 15)));
    pos_model[0] = 5;
    applyStimulus(6'd0, 4'd0, 4'd0, 4'd0);

    $display("[TB] rejected commands");
    rejectCmd("rej_multihot", 6'b000011, 4'd0, 4'd5, 4'd0);
    rejectCmd("rej_digit", 6'b000001, 4'hA, 4'd0, 4'd0);
    rejectCmd("rej_units", 6'b000100, 4'd0, 4'd0, 4'hF);
    rejectCmd("rej_nomotor", 6'b000000, 4'd0, 4'd5, 4'd0);

    $display("[TB] random moves");
    for (int k = 0; k < 6; k++) begin
      ra = int'($urandom_range(0, 5));
      rh = 4'($urandom_range(0, 9));
      rt = 4'($urandom_range(0, 9));
      ru = 4'($urandom_range(0, 9));
      runMove($sformatf("rand_%0d", k), ra, rh, rt, ru);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
